// File: rtl/quadrant_result_stage.sv
// ---------------------------------------------------------------------------
// quadrant_result_stage
//
// Purpose: folds raw CORDIC sin/cos back into the correct quadrant using the
// signed flip count from the angle normaliser. Negation saturates (MIN -> MAX).
// Results are optionally arithmetic-shifted into the output Q format and then
// queued in a small output FIFO with valid/ready handshakes on both sides.
// A counter tracks how many accepted samples needed a saturated negation.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready = occupancy < DEPTH
//   flips                 signed quadrant flip count (only flips mod 4 matters)
//   sin_in, cos_in        raw signed CORDIC outputs
//   tag_in                sideband tag carried alongside the sample
//   out_valid / out_ready output handshake for the FIFO head
//   sin_out, cos_out      corrected head sample, zero while out_valid = 0
//   tag_out               head tag, zero while out_valid = 0
//   sat_clr               synchronous clear of sat_count (wins over increment)
//   sat_count             saturating count of samples with a saturated negation
// ---------------------------------------------------------------------------
module quadrant_result_stage #(
  parameter int WIDTH     = 32,
  parameter int FLIP_W    = 3,
  parameter int TAG_W     = 4,
  parameter int OUT_SHIFT = 0,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FLIP_W-1:0]       flips,
  input  logic [WIDTH-1:0]        sin_in,
  input  logic [WIDTH-1:0]        cos_in,
  input  logic [TAG_W-1:0]        tag_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        sin_out,
  output logic [WIDTH-1:0]        cos_out,
  output logic [TAG_W-1:0]        tag_out,
  input  logic                    sat_clr,
  output logic [CNT_W-1:0]        sat_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [WIDTH-1:0] DATA_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] DATA_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic             sat;
  } neg_t;

  // Two's complement negation that clamps the single unrepresentable case.
  function automatic neg_t sat_neg(input logic [WIDTH-1:0] x);
    neg_t r;
    if (x == DATA_MIN) begin
      r.val = DATA_MAX;
      r.sat = 1'b1;
    end else begin
      r.val = -x;
      r.sat = 1'b0;
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Quadrant correction
  // -------------------------------------------------------------------------
  // Only flips mod 4 matters; the upper bits are folded into a sink so the
  // full-width port stays meaningful to the producer without lint noise.
  logic       unused_flips_hi;
  logic [1:0] quad;
  assign quad            = flips[1:0];
  assign unused_flips_hi = ^flips;

  neg_t                    neg_s;
  neg_t                    neg_c;
  logic signed [WIDTH-1:0] sin_corr;
  logic signed [WIDTH-1:0] cos_corr;
  logic                    corr_sat;
  logic        [WIDTH-1:0] sin_shift;
  logic        [WIDTH-1:0] cos_shift;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    neg_s    = sat_neg(sin_in);
    neg_c    = sat_neg(cos_in);
    sin_corr = sin_in;
    cos_corr = cos_in;
    corr_sat = 1'b0;
    unique case (quad)
      2'd0: begin
        // abs(c): only a negative cosine goes through the negator.
        sin_corr = sin_in;
        if (cos_in[WIDTH-1]) begin
          cos_corr = neg_c.val;
          corr_sat = neg_c.sat;
        end
      end
      2'd1: begin
        sin_corr = neg_c.val;
        cos_corr = sin_in;
        corr_sat = neg_c.sat;
      end
      2'd2: begin
        sin_corr = neg_s.val;
        cos_corr = neg_c.val;
        corr_sat = neg_s.sat | neg_c.sat;
      end
      default: begin
        sin_corr = cos_in;
        cos_corr = neg_s.val;
        corr_sat = neg_s.sat;
      end
    endcase
    // Sign-filling shift: rounds toward -inf.
    sin_shift = sin_corr >>> OUT_SHIFT;
    cos_shift = cos_corr >>> OUT_SHIFT;
  end

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sin_mem_q [DEPTH];
  logic [WIDTH-1:0] cos_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  logic push;
  logic pop;

  // Ready comes only from registered occupancy, never from out_ready.
  assign in_ready  = (occ_q < OCC_W'(DEPTH));
  assign out_valid = (occ_q != '0);
  // A sample presented during reset must not be captured.
  assign push      = in_valid && in_ready && !rst;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    sat_count_d = sat_count_q;

    // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (sat_clr) begin
      sat_count_d = '0;
    end else if (push && corr_sat && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      sat_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      sat_count_q <= sat_count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy gates
  // every read, and the outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      sin_mem_q[wr_ptr_q] <= sin_shift;
      cos_mem_q[wr_ptr_q] <= cos_shift;
      tag_mem_q[wr_ptr_q] <= tag_in;
    end
  end

  assign sin_out   = out_valid ? sin_mem_q[rd_ptr_q] : '0;
  assign cos_out   = out_valid ? cos_mem_q[rd_ptr_q] : '0;
  assign tag_out   = out_valid ? tag_mem_q[rd_ptr_q] : '0;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_quadrant_result_stage.sv
// ---------------------------------------------------------------------------
// tb_quadrant_result_stage
//
// Two instances share one stimulus stream: "a" with default parameters and
// "b" with OUT_SHIFT=2 and a 3-bit saturation counter. A queue-based model
// of the expected FIFO contents (stored unshifted) is checked on every
// falling edge, and directed scenarios pin hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_quadrant_result_stage;

  localparam int W  = 32;
  localparam int FW = 3;
  localparam int TW = 4;
  localparam int DEPTH = 2;
  localparam longint DMIN = -(64'sd1 <<< (W - 1));
  localparam longint DMAX = (64'sd1 <<< (W - 1)) - 1;
  localparam int CNT_A_MAX = 65535;
  localparam int CNT_B_MAX = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic          sat_clr;
  logic [FW-1:0] flips;
  logic [W-1:0]  sin_in;
  logic [W-1:0]  cos_in;
  logic [TW-1:0] tag_in;

  logic          a_in_ready, a_out_valid;
  logic [W-1:0]  a_sin, a_cos;
  logic [TW-1:0] a_tag;
  logic [15:0]   a_sat;

  logic          b_in_ready, b_out_valid;
  logic [W-1:0]  b_sin, b_cos;
  logic [TW-1:0] b_tag;
  logic [2:0]    b_sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quadrant_result_stage #(
    .WIDTH(W), .FLIP_W(FW), .TAG_W(TW), .OUT_SHIFT(0), .DEPTH(DEPTH), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .flips(flips), .sin_in(sin_in), .cos_in(cos_in), .tag_in(tag_in),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .sin_out(a_sin), .cos_out(a_cos), .tag_out(a_tag),
    .sat_clr(sat_clr), .sat_count(a_sat)
  );

  quadrant_result_stage #(
    .WIDTH(W), .FLIP_W(FW), .TAG_W(TW), .OUT_SHIFT(2), .DEPTH(DEPTH), .CNT_W(3)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .flips(flips), .sin_in(sin_in), .cos_in(cos_in), .tag_in(tag_in),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .sin_out(b_sin), .cos_out(b_cos), .tag_out(b_tag),
    .sat_clr(sat_clr), .sat_count(b_sat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: queue of expected (unshifted) samples plus counters.
  // ---------------------------------------------------------------------
  longint m_sin[$];
  longint m_cos[$];
  int     m_tag[$];
  int     m_cnt_a = 0;
  int     m_cnt_b = 0;
  bit     started = 1'b0;

  function automatic longint negv(input longint x);
    return (x == DMIN) ? DMAX : -x;
  endfunction

  function automatic logic [W-1:0] to_w(input longint x, input int sh);
    longint y;
    y = x >>> sh;
    return y[W-1:0];
  endfunction

  task automatic model_step();
    longint s, c, es, ec;
    int     q;
    bit     sat, acc, pop;
    if (rst) begin
      m_sin.delete(); m_cos.delete(); m_tag.delete();
      m_cnt_a = 0; m_cnt_b = 0;
      started = 1'b1;
      return;
    end
    if (!started) return;
    acc = in_valid && (m_sin.size() < DEPTH);
    pop = (m_sin.size() > 0) && out_ready;
    q = int'($signed(flips));
    q = ((q % 4) + 4) % 4;
    s = longint'($signed(sin_in));
    c = longint'($signed(cos_in));
    case (q)
      0:       begin es = s;        ec = (c < 0) ? negv(c) : c; sat = (c == DMIN); end
      1:       begin es = negv(c);  ec = s;                      sat = (c == DMIN); end
      2:       begin es = negv(s);  ec = negv(c);                sat = (s == DMIN) || (c == DMIN); end
      default: begin es = c;        ec = negv(s);                sat = (s == DMIN); end
    endcase
    if (sat_clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (acc && sat) begin
      if (m_cnt_a < CNT_A_MAX) m_cnt_a++;
      if (m_cnt_b < CNT_B_MAX) m_cnt_b++;
    end
    if (pop) begin
      void'(m_sin.pop_front()); void'(m_cos.pop_front()); void'(m_tag.pop_front());
    end
    if (acc) begin
      m_sin.push_back(es); m_cos.push_back(ec); m_tag.push_back(int'(tag_in));
    end
  endtask

  always @(posedge clk) model_step();

  task automatic compare_all();
    bit            v;
    logic [W-1:0]  es_a, ec_a, es_b, ec_b;
    logic [TW-1:0] et;
    v = (m_sin.size() > 0);
    es_a = v ? to_w(m_sin[0], 0) : '0;
    ec_a = v ? to_w(m_cos[0], 0) : '0;
    es_b = v ? to_w(m_sin[0], 2) : '0;
    ec_b = v ? to_w(m_cos[0], 2) : '0;
    et   = v ? TW'(m_tag[0]) : '0;
    check("a.in_ready",  64'(a_in_ready),  64'(m_sin.size() < DEPTH));
    check("a.out_valid", 64'(a_out_valid), 64'(v));
    check("a.sin_out",   64'(a_sin),       64'(es_a));
    check("a.cos_out",   64'(a_cos),       64'(ec_a));
    check("a.tag_out",   64'(a_tag),       64'(et));
    check("a.sat_count", 64'(a_sat),       64'(m_cnt_a));
    check("b.in_ready",  64'(b_in_ready),  64'(m_sin.size() < DEPTH));
    check("b.out_valid", 64'(b_out_valid), 64'(v));
    check("b.sin_out",   64'(b_sin),       64'(es_b));
    check("b.cos_out",   64'(b_cos),       64'(ec_b));
    check("b.tag_out",   64'(b_tag),       64'(et));
    check("b.sat_count", 64'(b_sat),       64'(m_cnt_b));
  endtask

  always @(negedge clk) if (started) compare_all();

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic send(input logic [FW-1:0] f, input logic [W-1:0] s,
                      input logic [W-1:0] c, input logic [TW-1:0] t);
    flips = f; sin_in = s; cos_in = c; tag_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    flips = '0; sin_in = '0; cos_in = '0; tag_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.out_valid", 64'(a_out_valid), 64'd0);
    check("reset.in_ready",  64'(a_in_ready),  64'd1);
    check("reset.sat_count", 64'(a_sat),       64'd0);

    // Quadrant 1 with default and shifted output formats.
    out_ready = 1'b1;
    send(3'd1, 32'h2000_0000, 32'h1000_0000, 4'd5);
    @(negedge clk);
    check("q1.out_valid", 64'(a_out_valid), 64'd1);
    check("q1.sin_out",   64'(a_sin), 64'hF000_0000);
    check("q1.cos_out",   64'(a_cos), 64'h2000_0000);
    check("q1.sat_count", 64'(a_sat), 64'd0);
    check("q1.shift.sin_out", 64'(b_sin), 64'hFC00_0000);
    check("q1.shift.cos_out", 64'(b_cos), 64'h0800_0000);

    // Quadrant 2 negating MIN saturates, then clear.
    send(3'd2, 32'h0000_0000, 32'h8000_0000, 4'd6);
    @(negedge clk);
    check("q2.sin_out",   64'(a_sin), 64'h0000_0000);
    check("q2.cos_out",   64'(a_cos), 64'h7FFF_FFFF);
    check("q2.sat_count", 64'(a_sat), 64'd1);
    check("q2.shift.cos_out", 64'(b_cos), 64'h1FFF_FFFF);
    sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    @(negedge clk);
    check("clr.sat_count", 64'(a_sat), 64'd0);

    // flips 3 and -1 are the same quadrant; q0 takes abs of cosine.
    send(3'd3, 32'h4000_0000, 32'h8000_0000, 4'd7);
    @(negedge clk);
    check("q3.sin_out", 64'(a_sin), 64'h8000_0000);
    check("q3.cos_out", 64'(a_cos), 64'hC000_0000);
    send(3'b111, 32'h4000_0000, 32'h8000_0000, 4'd7);
    @(negedge clk);
    check("qm1.sin_out",   64'(a_sin), 64'h8000_0000);
    check("qm1.cos_out",   64'(a_cos), 64'hC000_0000);
    check("qm1.sat_count", 64'(a_sat), 64'd0);
    send(3'd0, 32'h0000_0000, 32'hFFFF_0000, 4'd8);
    @(negedge clk);
    check("q0.cos_out", 64'(a_cos), 64'h0001_0000);

    // Back-pressure: tags 1,2,3 with the consumer stalled.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; flips = '0;
    sin_in = 32'd1; cos_in = 32'd1; tag_in = 4'd1;
    @(posedge clk); #1 tag_in = 4'd2;
    @(posedge clk); #1 tag_in = 4'd3;
    @(negedge clk);
    check("bp.full.in_ready", 64'(a_in_ready), 64'd0);
    check("bp.full.tag_out",  64'(a_tag),      64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp.held.in_ready", 64'(a_in_ready), 64'd0);
    check("bp.held.tag_out",  64'(a_tag),      64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.drain.tag2", 64'(a_tag), 64'd2);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp.drain.tag3", 64'(a_tag), 64'd3);
    @(negedge clk);
    check("bp.empty.out_valid", 64'(a_out_valid), 64'd0);

    // Reset mid-operation with two entries held and sat_count = 5.
    repeat (5) send(3'd2, 32'h8000_0000, 32'h0000_0000, 4'd9);
    @(negedge clk);
    check("pre_rst.sat_count", 64'(a_sat), 64'd5);
    out_ready = 1'b0; in_valid = 1'b1; flips = '0;
    sin_in = 32'd5; cos_in = 32'd5; tag_in = 4'd10;
    @(negedge clk);
    check("pre_rst.in_ready", 64'(a_in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst.out_valid", 64'(a_out_valid), 64'd0);
    check("rst.sin_out",   64'(a_sin),       64'd0);
    check("rst.cos_out",   64'(a_cos),       64'd0);
    check("rst.tag_out",   64'(a_tag),       64'd0);
    check("rst.sat_count", 64'(a_sat),       64'd0);
    check("rst.in_ready",  64'(a_in_ready),  64'd1);

    // Counter saturation on the 3-bit instance; sustained streaming.
    out_ready = 1'b1;
    repeat (10) send(3'd2, 32'h8000_0000, 32'h0000_0000, 4'd11);
    @(negedge clk);
    check("sat.a.sat_count", 64'(a_sat), 64'd10);
    check("sat.b.sat_count", 64'(b_sat), 64'd7);

    // Randomised traffic, including occasional reset and clear.
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sat_clr   = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      flips     = FW'($urandom);
      sin_in    = rand_val();
      cos_in    = rand_val();
      tag_in    = TW'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0; sat_clr = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
